// File: rtl/ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ones_pattern_gen
// Brief    : Enumerates every LEN-bit word with exactly K set bits, in
//            ascending order, as {A,B} operand pairs over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module ones_pattern_gen #(
  parameter int BITS = 2,
  parameter int LEN  = BITS * 2,
  parameter int CW   = $clog2(LEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [CW-1:0]   i_count,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [BITS-1:0] o_argA,
  output logic [BITS-1:0] o_argB,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [LEN:0]    o_emitted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] c_len_cw = CW'(LEN);
  localparam logic [LEN:0]  c_one    = (LEN + 1)'(1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_k, w_k_nxt;
  logic [LEN:0]    r_cand, w_cand_nxt;
  logic [BITS-1:0] r_arga, w_arga_nxt;
  logic [BITS-1:0] r_argb, w_argb_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [LEN:0]    r_emitted, w_emitted_nxt;
  logic [CW-1:0]   w_pop;

  function automatic logic [CW-1:0] popcnt(input logic [LEN-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LEN; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign w_pop = popcnt(r_cand[LEN-1:0]);

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_cand_nxt    = r_cand;
    w_arga_nxt    = r_arga;
    w_argb_nxt    = r_argb;
    w_valid_nxt   = r_valid;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_emitted_nxt = r_emitted;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_count > c_len_cw) begin
            w_err_nxt = 1'b1;
          end else begin
            w_k_nxt       = i_count;
            w_cand_nxt    = '0;
            w_emitted_nxt = '0;
            w_state_nxt   = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // The carry into cand[LEN] marks exhaustion, so 0 is never revisited.
        if (r_cand[LEN]) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_pop == r_k) begin
          w_arga_nxt  = r_cand[LEN-1:BITS];
          w_argb_nxt  = r_cand[BITS-1:0];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cand_nxt = r_cand + c_one;
        end
      end
      S_HOLD: begin
        if (i_ready) begin
          w_valid_nxt   = 1'b0;
          w_emitted_nxt = r_emitted + c_one;
          w_cand_nxt    = r_cand + c_one;
          w_state_nxt   = S_SCAN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_cand    <= '0;
      r_arga    <= '0;
      r_argb    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_emitted <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_cand    <= w_cand_nxt;
      r_arga    <= w_arga_nxt;
      r_argb    <= w_argb_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_emitted <= w_emitted_nxt;
    end
  end

  assign o_valid   = r_valid;
  assign o_argA    = r_arga;
  assign o_argB    = r_argb;
  assign o_busy    = (r_state == S_SCAN) || (r_state == S_HOLD);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_emitted = r_emitted;

endmodule
`default_nettype wire

// File: tb/tb_ones_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ones_pattern_gen
// Brief    : Directed scoreboard bench for ones_pattern_gen (BITS=2, LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ones_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] count;
  logic       ready;
  logic       valid;
  logic [1:0] arga, argb;
  logic       busy, done, err;
  logic [4:0] emitted;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];

  ones_pattern_gen #(.BITS(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_count   (count),
    .i_ready   (ready),
    .o_valid   (valid),
    .o_argA    (arga),
    .o_argB    (argb),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_emitted (emitted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_arg"}, 32'({arga, argb}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_emitted"}, 32'(emitted), 0);
  endtask

  // Starts a run with ones-count k; holds ready low for `stall` cycles on the first pattern.
  task automatic run_k(input int k, input int stall);
    int   exp_n;
    int   first_v;
    int   cyc;
    logic seen_first;
    logic got_done;
    logic [3:0] w;
    exp_q.delete();
    first_v = -1;
    for (int v = 0; v < 16; v++) begin
      w = v[3:0];
      if ($countones(w) == k) begin
        exp_q.push_back(w);
        if (first_v < 0) first_v = v;
      end
    end
    exp_n = exp_q.size();
    count = 3'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = (stall == 0);
    check("busy_after_start", 32'(busy), 1);
    cyc = 1;
    seen_first = 1'b0;
    got_done = 1'b0;
    while (cyc < 400 && !got_done) begin
      if (valid) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          check("first_latency", cyc, first_v + 2);
          for (int s = 0; s < stall; s++) begin
            check("stall_arg", 32'({arga, argb}), 32'(exp_q[0]));
            check("stall_emitted", 32'(emitted), 0);
            check("stall_valid", 32'(valid), 1);
            tick();
            cyc++;
          end
          ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
          check("extra_pattern", 32'({arga, argb}), 32'hFFFF);
        end else begin
          check("pattern", 32'({arga, argb}), 32'(exp_q.pop_front()));
        end
        check("ones_count", $countones({arga, argb}), k);
        tick();
        cyc++;
        check("valid_gap", 32'(valid), 0);
      end else if (done) begin
        got_done = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check("done_seen", 32'(got_done), 1);
    check("emitted_total", 32'(emitted), exp_n);
    check("queue_drained", exp_q.size(), 0);
    check("no_valid_with_done", 32'(valid), 0);
    tick();
    check("done_pulse_width", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("emitted_kept", 32'(emitted), exp_n);
  endtask

  initial begin
    int guard;
    rst   = 1'b1;
    start = 1'b0;
    count = '0;
    ready = 1'b0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("idle_quiet");

    run_k(2, 0);
    run_k(0, 0);
    run_k(4, 0);

    // Out-of-range ones-count is rejected with a single error pulse.
    count = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", 32'(err), 1);
    check("err_valid", 32'(valid), 0);
    check("err_busy", 32'(busy), 0);
    check("err_done", 32'(done), 0);
    tick();
    check("err_cleared", 32'(err), 0);
    check("err_still_idle", 32'(busy), 0);
    run_k(1, 5);

    // Reset while a pattern is held.
    count = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    guard = 0;
    while (!valid && guard < 50) begin
      tick();
      guard++;
    end
    check("hold_reached", 32'(valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("mid_reset");
    run_k(3, 0);

    for (int r = 0; r < 4; r++) begin
      run_k(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
